// File: rtl/eth_tx_mac_framer.sv
// eth_tx_mac_framer: GMII-style Ethernet TX framer (preamble, SFD, data, pad, CRC-32 FCS, IFG); define ETH_TX_PAD_EN to pad frames to 60 data bytes
module eth_tx_mac_framer #(
  parameter int IFG_CYCLES = 12
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       tx_fifoempty,
  input  logic [7:0] tx_fifodata,
  input  logic       tx_fifoeof,
  output logic       tx_macread,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);
`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;
  localparam logic [15:0] MIN_LEN = 16'd60;
`else
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, FCS, IFG} state_t;
`endif
  localparam logic [15:0] IFG_N = 16'(IFG_CYCLES);
  state_t      state, state_n, es;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [31:0] crc, crc_n;
  logic [7:0]  txd_n;
  logic        en_n, done_n, urun_n;
  logic [1:0]  fi;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  // next state and next registered outputs; the state names the byte the next enabled edge drives,
  // and an eof seen with an empty FIFO in DATA is treated as the first pad/FCS cycle so tx_en never gaps
  always_comb begin
    tx_macread = clk_en && state == DATA && !tx_fifoempty;
    tx_busy = state != IDLE;
    cnt_inc = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
    fi = state == FCS ? cnt[1:0] : 2'd0;
    es = state;
    if (state == DATA && tx_fifoempty && tx_fifoeof)
`ifdef ETH_TX_PAD_EN
      es = cnt < MIN_LEN ? PAD : FCS;
`else
      es = FCS;
`endif
    state_n = state;
    cnt_n = cnt;
    crc_n = crc;
    txd_n = 8'h00;
    en_n = 1'b0;
    done_n = 1'b0;
    urun_n = 1'b0;
    case (es)
      IDLE: begin
        if (!tx_fifoempty) begin
          state_n = PREAMBLE;
          cnt_n = 16'd1;
          txd_n = 8'h55;
          en_n = 1'b1;
        end
      end
      PREAMBLE: begin
        txd_n = 8'h55;
        en_n = 1'b1;
        cnt_n = cnt_inc;
        state_n = cnt_inc == 16'd7 ? SFD : PREAMBLE;
      end
      SFD: begin
        txd_n = 8'hD5;
        en_n = 1'b1;
        state_n = DATA;
        cnt_n = 16'd0;
        crc_n = '1;
      end
      DATA: begin
        if (!tx_fifoempty) begin
          txd_n = tx_fifodata;
          en_n = 1'b1;
          crc_n = crc_upd(crc, tx_fifodata);
          cnt_n = cnt_inc;
          if (tx_fifoeof) begin
`ifdef ETH_TX_PAD_EN
            state_n = cnt_inc < MIN_LEN ? PAD : FCS;
            cnt_n = cnt_inc < MIN_LEN ? cnt_inc : 16'd0;
`else
            state_n = FCS;
            cnt_n = 16'd0;
`endif
          end
        end else begin
          urun_n = 1'b1;
          state_n = IFG;
          cnt_n = 16'd0;
        end
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        en_n = 1'b1;
        crc_n = crc_upd(crc, 8'h00);
        state_n = cnt_inc >= MIN_LEN ? FCS : PAD;
        cnt_n = cnt_inc >= MIN_LEN ? 16'd0 : cnt_inc;
      end
`endif
      FCS: begin
        txd_n = ~crc[8*fi +: 8];
        en_n = 1'b1;
        done_n = fi == 2'd3;
        state_n = fi == 2'd3 ? IFG : FCS;
        cnt_n = fi == 2'd3 ? 16'd0 : {14'd0, fi} + 16'd1;
      end
      IFG: begin
        state_n = cnt_inc >= IFG_N ? IDLE : IFG;
        cnt_n = cnt_inc >= IFG_N ? 16'd0 : cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters, CRC and registered GMII outputs advance only on enabled cycles
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      crc <= '1;
      txd <= '0;
      tx_en <= 1'b0;
      tx_done <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (clk_en) begin
      state <= state_n;
      cnt <= cnt_n;
      crc <= crc_n;
      txd <= txd_n;
      tx_en <= en_n;
      tx_done <= done_n;
      tx_underrun <= urun_n;
    end
  end
endmodule

// File: tb/tb_eth_tx_mac_framer.sv
// tb_eth_tx_mac_framer: scoreboard bench for eth_tx_mac_framer (honours ETH_TX_PAD_EN)
module tb_eth_tx_mac_framer;
`ifdef ETH_TX_PAD_EN
  localparam int PAD_MIN = 60;
`else
  localparam int PAD_MIN = 0;
`endif
  typedef struct {
    int len;
    int gap;
    int done;
    bit urun;
    bit res;
  } info_t;
  logic       clk_i = 1'b0;
  logic       reset, clk_en, tx_fifoempty, tx_fifoeof;
  logic [7:0] tx_fifodata;
  logic       tx_macread, tx_en, tx_busy, tx_done, tx_underrun;
  logic [7:0] txd;
  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] fq[$];
  logic [7:0] exp_q[$];
  info_t      info_q[$];
  info_t      cur;
  logic [7:0] fr[$];
  logic [7:0] run_b[$];
  bit         toggle = 1'b0;
  bit         in_run = 1'b0;
  int         run_len = 0;
  int         gap = 0;
  int         done_seen = 0;
  logic       ce_q = 1'b1;
  logic [11:0] prev = '0;

  eth_tx_mac_framer #(.IFG_CYCLES(12)) dut (
    .clk_i(clk_i), .reset(reset), .clk_en(clk_en), .tx_fifoempty(tx_fifoempty),
    .tx_fifodata(tx_fifodata), .tx_fifoeof(tx_fifoeof), .tx_macread(tx_macread),
    .txd(txd), .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) ce_q <= clk_en;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] c;
    c = '1;
    for (int i = 8; i < run_b.size(); i++) c = crc_step(c, run_b[i]);
    return c;
  endfunction

  task automatic drive();
    tx_fifoempty = fq.size() == 0 ? 1'b1 : !fq[0][9];
    tx_fifoeof = fq.size() == 0 ? 1'b0 : fq[0][8];
    tx_fifodata = fq.size() == 0 ? 8'h00 : fq[0][7:0];
  endtask

  task automatic cyc();
    logic pop, mk;
    @(negedge clk_i);
    pop = tx_macread;
    mk = clk_en && fq.size() != 0 && !fq[0][9];
    @(posedge clk_i);
    #1;
    if ((pop || mk) && fq.size() != 0) void'(fq.pop_front());
    clk_en = toggle ? ~clk_en : 1'b1;
    drive();
  endtask

  // mode 0: eof on last byte; 1: eof presented with empty FIFO after the data; 2: no eof (underrun)
  task automatic send_frame(input int mode, input int gp, input int trunc, input bit ovr, input logic [31:0] kf);
    logic [7:0]  e[$];
    logic [31:0] c;
    info_t       inf;
    int          n;
    n = fr.size();
    for (int i = 0; i < n; i++) fq.push_back({1'b1, mode == 0 && i == n - 1, fr[i]});
    if (mode == 1) fq.push_back(10'h100);
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    c = '1;
    for (int i = 0; i < n; i++) begin
      e.push_back(fr[i]);
      c = crc_step(c, fr[i]);
    end
    if (mode != 2) begin
      for (int i = n; i < PAD_MIN; i++) begin
        e.push_back(8'h00);
        c = crc_step(c, 8'h00);
      end
      c = ovr ? kf : ~c;
      for (int i = 0; i < 4; i++) e.push_back(c[8*i +: 8]);
    end
    while (trunc >= 0 && e.size() > trunc) void'(e.pop_back());
    foreach (e[i]) exp_q.push_back(e[i]);
    inf.len = e.size();
    inf.gap = gp;
    inf.done = (mode != 2 && trunc < 0) ? 1 : 0;
    inf.urun = mode == 2;
    inf.res = mode != 2 && trunc < 0;
    info_q.push_back(inf);
    drive();
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      cyc();
      t++;
    end while (t < 3000 && (fq.size() != 0 || exp_q.size() != 0 || info_q.size() != 0 || in_run || tx_busy));
    chk("drain_timeout", 64'(t >= 3000), 0);
  endtask

  // scoreboard monitor: samples away from the edge; only samples following an enabled edge carry new data
  always @(negedge clk_i) begin
    if (reset) chk("reset_outs", {51'd0, txd, tx_en, tx_busy, tx_done, tx_underrun, tx_macread}, 0);
    if (!clk_en) chk("macread_gated", 64'(tx_macread), 0);
    if (!ce_q && !reset) chk("hold", {52'd0, txd, tx_en, tx_busy, tx_done, tx_underrun}, {52'd0, prev});
    if (ce_q || reset) begin
      if (tx_en) begin
        if (!in_run) begin
          in_run = 1'b1;
          run_len = 0;
          done_seen = 0;
          run_b.delete();
          if (info_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            cur = '{len: 0, gap: -1, done: 0, urun: 1'b0, res: 1'b0};
          end else cur = info_q.pop_front();
          if (cur.gap >= 0) chk("ifg_gap", 64'(gap), 64'(cur.gap));
        end
        run_len++;
        run_b.push_back(txd);
        if (tx_done) done_seen++;
        chk("busy", 64'(tx_busy), 1);
        chk("underrun_in_frame", 64'(tx_underrun), 0);
        if (exp_q.size() == 0) chk("extra_byte", 64'(txd), 64'h100);
        else chk("txd", 64'(txd), 64'(exp_q.pop_front()));
      end else begin
        chk("txd_idle", 64'(txd), 0);
        if (in_run) begin
          in_run = 1'b0;
          gap = 0;
          chk("tx_en_len", 64'(run_len), 64'(cur.len));
          chk("done_count", 64'(done_seen), 64'(cur.done));
          chk("underrun_pulse", 64'(tx_underrun), 64'(cur.urun));
          if (cur.res) chk("crc_residue", 64'(residue()), 64'hDEBB20E3);
        end
        gap++;
      end
    end
    prev = {txd, tx_en, tx_busy, tx_done, tx_underrun};
  end

  initial begin
    int k, tr;
    reset = 1'b1;
    clk_en = 1'b1;
    drive();
    repeat (3) @(posedge clk_i);
    #1 reset = 1'b0;
    fr.delete();
    fr.push_back(8'hAB);
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
`ifdef ETH_TX_PAD_EN
    send_frame(0, -1, -1, 1'b0, 0);
`else
    send_frame(0, -1, -1, 1'b1, 32'hCBF43926);
`endif
    drain();
    fr.delete();
    for (int i = 0; i < 64; i++) fr.push_back(8'(i * 3));
    send_frame(0, -1, -1, 1'b0, 0);
    fr.delete();
    for (int i = 0; i < 64; i++) fr.push_back(~8'(i));
    send_frame(0, 12, -1, 1'b0, 0);
    drain();
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(8'hA0 + 8'(i));
    send_frame(2, -1, -1, 1'b0, 0);
    drain();
    fr.delete();
    fr.push_back(8'h11);
    fr.push_back(8'h22);
    fr.push_back(8'h33);
    send_frame(1, -1, -1, 1'b0, 0);
    drain();
    toggle = 1'b1;
    fr.delete();
    fr.push_back(8'hAB);
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    toggle = 1'b0;
    cyc();
    fr.delete();
    for (int i = 0; i < 5; i++) fr.push_back(8'hF0 + 8'(i));
    tr = 8 + (5 < PAD_MIN ? PAD_MIN : 5) + 1;
    send_frame(0, -1, tr, 1'b0, 0);
    k = 0;
    for (int t = 0; t < 400 && k <= tr; t++) begin
      cyc();
      if (tx_en) k++;
    end
    chk("reset_trigger", 64'(k), 64'(tr + 1));
    reset = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset = 1'b0;
    drive();
    fr.delete();
    fr.push_back(8'h5A);
    fr.push_back(8'hC3);
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
